// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: op encodings, divider FSM states
// and the default divide latency.
package mdu_pkg;

  typedef enum logic [2:0] {
    DIV  = 3'b100,
    DIVU = 3'b101,
    REM  = 3'b110,
    REMU = 3'b111
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  localparam int unsigned DIV_WIDTH   = 32;
  // Edges from the start edge (inclusive) until valid is visible.
  localparam int unsigned DIV_LATENCY = DIV_WIDTH + 1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, trial-subtract
// the divisor and keep the difference when it does not borrow.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Trial subtraction is one bit wider than the shifted remainder so the
  // borrow is visible even when the shifted remainder overflows WIDTH bits.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, dvs};
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH+1]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative RV32M divide/remainder unit, restoring algorithm, one quotient bit
// per clock. Optional macro SEQ_DIV_FAST_EN retires divide-by-zero, signed
// overflow and |divisor| > |dividend| directly from IDLE.
module seq_divider
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rem_sel_q, rem_sel_d, neg_q, neg_d, rneg_q, rneg_d;
  logic             dz_q, dz_d, ovf_q, ovf_d, busy_q, busy_d, valid_q, valid_d;

  div_op_t          op;
  logic             op_signed, op_rem, a_neg, b_neg, is_dz, is_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, step_rem, step_quo, quo_fix, rem_fix, final_res;
`ifdef SEQ_DIV_FAST_EN
  logic             fast_hit;
  logic [WIDTH-1:0] fast_quo, fast_rem;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvs      (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Decode the requested op and operand magnitudes/special cases at start.
  always_comb begin
    op        = funct3[2] ? div_op_t'(funct3) : DIVU;
    op_signed = (op == DIV) || (op == REM);
    op_rem    = (op == REM) || (op == REMU);
    a_neg     = op_signed & dividend[WIDTH-1];
    b_neg     = op_signed & divisor[WIDTH-1];
    a_mag     = a_neg ? -dividend : dividend;
    b_mag     = b_neg ? -divisor : divisor;
    is_dz     = (divisor == '0);
    is_ovf    = op_signed && (dividend == MIN_NEG) && (divisor == '1);
`ifdef SEQ_DIV_FAST_EN
    fast_hit  = is_dz | is_ovf | (b_mag > a_mag);
    fast_quo  = is_dz ? '1 : (is_ovf ? MIN_NEG : '0);
    fast_rem  = is_ovf ? '0 : dividend;
`endif
  end

  // Sign fix-up of the final iteration, with special cases forced on top.
  always_comb begin
    quo_fix = neg_q ? -step_quo : step_quo;
    rem_fix = rneg_q ? -step_rem : step_rem;
    if (dz_q) begin
      quo_fix = '1;
    end
    if (ovf_q) begin
      quo_fix = MIN_NEG;
      rem_fix = '0;
    end
    final_res = rem_sel_q ? rem_fix : quo_fix;
  end

  // FSM next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    rem_sel_d = rem_sel_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_sel_d = op_rem;
          neg_d     = a_neg ^ b_neg;
          rneg_d    = a_neg;
          dz_d      = is_dz;
          ovf_d     = is_ovf;
          quo_d     = a_mag;
          dvs_d     = b_mag;
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = CALC;
`ifdef SEQ_DIV_FAST_EN
          if (fast_hit) begin
            state_d  = DONE;
            result_d = op_rem ? fast_rem : fast_quo;
          end
`endif
        end
      end
      CALC: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = final_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  // State and registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      rem_sel_q <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      rem_sel_q <= rem_sel_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with a result scoreboard.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b101;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, valid;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

`ifdef SEQ_DIV_FAST_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  seq_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .funct3   (funct3),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .valid    (valid),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected latency model: fast-path cases retire in one edge when enabled.
  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [31:0] am, bm;
    logic        hit;
    sgn = f3[2] & ~f3[0];
    am  = (sgn && a[31]) ? -a : a;
    bm  = (sgn && b[31]) ? -b : b;
    hit = (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (bm > am);
    return (FAST_EN && hit) ? 1 : 33;
  endfunction

  // Scoreboard: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid_outstanding", 32'(exp_q.size()), 32'd1);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    @(negedge clk);
    funct3   = f3;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0BAD_F00D;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 1;
    bc  = 0;
    forever begin
      if (busy === 1'b1) bc++;
      if (valid === 1'b1 || lat >= 100) break;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat, bc, el;
    el = exp_lat(f3, a, b);
    start_op(f3, a, b, exp);
    wait_done(lat, bc);
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(el));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(el));
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, 32'(valid), 32'd0);
    check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    check({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    int lat, bc;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op("divu_100_7",   3'b101, 32'd100,        32'd7,          32'd14);
    run_op("remu_100_7",   3'b111, 32'd100,        32'd7,          32'd2);
    run_op("div_m100_7",   3'b100, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2);
    run_op("rem_m100_7",   3'b110, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE);
    run_op("divu_25_0",    3'b101, 32'd25,         32'd0,          32'hFFFF_FFFF);
    run_op("remu_25_0",    3'b111, 32'd25,         32'd0,          32'd25);
    run_op("div_m25_0",    3'b100, 32'hFFFF_FFE7,  32'd0,          32'hFFFF_FFFF);
    run_op("rem_m25_0",    3'b110, 32'hFFFF_FFE7,  32'd0,          32'hFFFF_FFE7);
    run_op("div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
    run_op("rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0);
    run_op("div_7_m2",     3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD);
    run_op("rem_7_m2",     3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1);
    run_op("divu_max_2",   3'b101, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF);
    run_op("f3_001_divu",  3'b001, 32'd100,        32'd7,          32'd14);
    run_op("divu_3_10",    3'b101, 32'd3,          32'd10,         32'd0);
    run_op("remu_3_10",    3'b111, 32'd3,          32'd10,         32'd3);

    // start re-pulsed with new operands mid-operation must be ignored
    start_op(3'b101, 32'd100, 32'd7, 32'd14);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    funct3   = 3'b101;
    dividend = 32'd81;
    divisor  = 32'd9;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bc);
    check("repulse_valid", 32'(valid), 32'd1);
    check("repulse_busy_total", 32'(bc + 10), 32'd33);
    repeat (40) @(posedge clk);
    #1;
    check("repulse_idle_busy", 32'(busy), 32'd0);
    check("repulse_queue_empty", 32'(exp_q.size()), 32'd0);

    // asynchronous reset mid-CALC clears outputs without a clock edge
    start_op(3'b101, 32'd200, 32'd3, 32'd66);
    repeat (14) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_result", result, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("arst_no_late_valid_busy", 32'(busy), 32'd0);
    run_op("divu_81_9",    3'b101, 32'd81,         32'd9,          32'd9);

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
